// File: rtl/parity_frame_arbiter.sv
// Round-robin arbiter feeding one shared serial parity generator: grants a requester,
// shifts its word out LSB-first and appends an even/odd parity beat.
module parity_frame_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned ODD   = 0,
    localparam int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   data_in,
    output logic [NREQ-1:0]         gnt,
    output logic                    busy,
    output logic                    ser_valid,
    output logic                    ser_out,
    output logic                    ser_last,
    input  logic                    ser_ready,
    output logic [IDW-1:0]          ser_id
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic OddBit = (ODD != 0);

    typedef enum logic [1:0] {StIdle, StData, StPar} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             acc_q, acc_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;

    logic [IDW-1:0]   sel;
    logic             sel_valid;
    logic [IDW-1:0]   ptr_next;
    logic             decide;

    // First asserted request at or after the pointer, wrapping around.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        sel       = '0;
        sel_valid = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!sel_valid && req[idx]) begin
                sel       = IDW'(idx);
                sel_valid = 1'b1;
            end
        end
    end

    assign ptr_next = (sel == IDW'(NREQ - 1)) ? '0 : sel + IDW'(1);

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        gnt_d   = '0;
        decide  = 1'b0;

        unique case (state_q)
            StIdle: begin
                decide = 1'b1;
            end
            StData: begin
                if (ser_ready) begin
                    acc_d   = acc_q ^ shift_q[0];
                    shift_d = shift_q >> 1;
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = StPar;
                    end
                end
            end
            StPar: begin
                if (ser_ready) begin
                    decide  = 1'b1;
                    state_d = StIdle;
                    id_d    = '0;
                end
            end
            default: state_d = StIdle;
        endcase

        // A decision with a live request starts the next frame with no gap cycle.
        if (decide && sel_valid) begin
            state_d    = StData;
            gnt_d[sel] = 1'b1;
            shift_d    = data_in[32'(sel) * WIDTH +: WIDTH];
            id_d       = sel;
            ptr_d      = ptr_next;
            cnt_d      = '0;
            acc_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            shift_q <= '0;
            cnt_q   <= '0;
            acc_q   <= 1'b0;
            ptr_q   <= '0;
            id_q    <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            gnt_q   <= gnt_d;
        end
    end

    always_comb begin
        ser_out = 1'b0;
        if (state_q == StData) begin
            ser_out = shift_q[0];
        end else if (state_q == StPar) begin
            ser_out = acc_q ^ OddBit;
        end
    end

    assign gnt       = gnt_q;
    assign busy      = (state_q != StIdle);
    assign ser_valid = (state_q != StIdle);
    assign ser_last  = (state_q == StPar);
    assign ser_id    = id_q;

endmodule

// File: tb/tb_parity_frame_arbiter.sv
// Self-checking bench: even and odd parity instances share stimulus and are compared
// against a frame-level model of arbitration order and serial content.
module tb_parity_frame_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NREQ-1:0] req;
    logic [NREQ*W-1:0] data_in;
    logic            ser_ready;

    logic [NREQ-1:0] gnt0, gnt1;
    logic            busy0, busy1, ser_valid0, ser_valid1;
    logic            ser_out0, ser_out1, ser_last0, ser_last1;
    logic [1:0]      ser_id0, ser_id1;

    int total = 0;
    int bad   = 0;
    int ptr_m = 0;

    always #5 clk = ~clk;

    parity_frame_arbiter #(.NREQ(NREQ), .WIDTH(W), .ODD(0)) dut_even (
        .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in), .gnt(gnt0), .busy(busy0),
        .ser_valid(ser_valid0), .ser_out(ser_out0), .ser_last(ser_last0),
        .ser_ready(ser_ready), .ser_id(ser_id0)
    );

    parity_frame_arbiter #(.NREQ(NREQ), .WIDTH(W), .ODD(1)) dut_odd (
        .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in), .gnt(gnt1), .busy(busy1),
        .ser_valid(ser_valid1), .ser_out(ser_out1), .ser_last(ser_last1),
        .ser_ready(ser_ready), .ser_id(ser_id1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        for (int i = 0; i < NREQ; i++) begin
            if (r[(p + i) % NREQ]) return (p + i) % NREQ;
        end
        return -1;
    endfunction

    // Called just before a decision edge: who wins, with which word.
    task automatic predict(output bit has, output int id, output logic [W-1:0] word);
        id   = pick(req, ptr_m);
        has  = (id >= 0);
        word = '0;
        if (has) begin
            word  = data_in[id*W +: W];
            ptr_m = (id + 1) % NREQ;
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_gnt"}, gnt0, 0);
        chk({tag, "_busy"}, busy0, 0);
        chk({tag, "_valid"}, ser_valid0, 0);
        chk({tag, "_last"}, ser_last0, 0);
        chk({tag, "_out"}, ser_out0, 0);
        chk({tag, "_id"}, ser_id0, 0);
        chk({tag, "_gnt_odd"}, gnt1, 0);
        chk({tag, "_valid_odd"}, ser_valid1, 0);
    endtask

    // Entered just after the grant edge; mode 0=always ready, 1=pattern 1,0,0, 2=random.
    task automatic do_frame(input int id, input logic [W-1:0] word, input int mode,
                            input logic [NREQ-1:0] req_after, input bit scramble,
                            input bit withdraw, input int abort_k,
                            output bit has, output int nid, output logic [W-1:0] nword);
        logic [NREQ-1:0] g;
        bit first;
        bit rdy;
        int k;
        int cyc;
        int stalls;
        g = '0;
        g[id] = 1'b1;
        has = 0;
        nid = -1;
        nword = '0;
        chk("gnt", gnt0, g);
        chk("gnt_odd", gnt1, g);
        req = req_after;
        if (scramble) data_in = $urandom;
        k = 0;
        cyc = 0;
        stalls = 0;
        first = 1;
        while (k <= W) begin
            if (k == abort_k) return;
            if (!first) chk("gnt_mid", gnt0, 0);
            chk("valid", ser_valid0, 1);
            chk("busy", busy0, 1);
            chk("last", ser_last0, (k == W));
            chk("ser_id", ser_id0, id);
            chk("out_even", ser_out0, (k < W) ? word[k] : ^word);
            chk("out_odd", ser_out1, (k < W) ? word[k] : ~^word);
            case (mode)
                0: rdy = 1'b1;
                1: rdy = (cyc % 3 == 0);
                default: rdy = (stalls >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
            endcase
            stalls = rdy ? 0 : stalls + 1;
            if (withdraw) begin
                if (k == 2) req[1] = 1'b1;
                if (k == 5) req[1] = 1'b0;
            end
            ser_ready = rdy;
            if (rdy && k == W) predict(has, nid, nword);
            step();
            first = 0;
            cyc++;
            if (rdy) k++;
        end
        ser_ready = 1'b0;
    endtask

    initial begin
        bit has;
        int id;
        logic [W-1:0] word;
        logic [NREQ-1:0] rr_after [7];
        int rr_ids [7];
        logic [W-1:0] rr_words [4];
        int chain;
        logic [NREQ-1:0] ra;

        rr_after = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1010, 4'b1010, 4'b0000};
        rr_ids   = '{0, 1, 2, 3, 0, 1, 3};
        rr_words = '{8'h11, 8'h22, 8'h33, 8'h44};

        rst_n = 1'b0;
        req = '0;
        data_in = '0;
        ser_ready = 1'b0;
        step();
        step();
        check_idle("reset");
        rst_n = 1'b1;
        ptr_m = 0;
        step();
        check_idle("idle_noreq");

        // Single even frame of 0xA5.
        req = 4'b0001;
        data_in = 32'h0000_00A5;
        predict(has, id, word);
        step();
        do_frame(id, word, 0, '0, 1, 0, -1, has, id, word);
        chk("a5_chain", has, 0);
        check_idle("a5_end");

        // Parity of 0x07 then 0x00.
        req = 4'b0100;
        data_in = 32'h0007_0000;
        predict(has, id, word);
        step();
        do_frame(id, word, 0, 4'b1000, 0, 0, -1, has, id, word);
        chk("p07_chain", has, 1);
        do_frame(id, word, 0, '0, 0, 0, -1, has, id, word);
        check_idle("p00_end");

        // Round robin with all requests held, then 1010.
        data_in = 32'h4433_2211;
        req = 4'b1111;
        predict(has, id, word);
        step();
        for (int f = 0; f < 7; f++) begin
            chk("rr_has", has, 1);
            do_frame(rr_ids[f], rr_words[rr_ids[f]], 0, rr_after[f], 0, 0, -1, has, id, word);
        end
        chk("rr_chain", has, 0);
        check_idle("rr_end");

        // Backpressure on the 0xA5 frame.
        req = 4'b0001;
        data_in = 32'h0000_00A5;
        predict(has, id, word);
        step();
        do_frame(id, word, 1, '0, 0, 0, -1, has, id, word);
        check_idle("bp_end");

        // Withdrawal of req[1] mid-frame, and data_in changed after grant.
        req = 4'b0001;
        data_in = $urandom;
        predict(has, id, word);
        step();
        do_frame(id, word, 0, '0, 1, 1, -1, has, id, word);
        chk("wd_chain", has, 0);
        check_idle("wd_end");

        // Randomised requests, words, backpressure and back-to-back chains.
        for (int n = 0; n < 25; n++) begin
            req = 4'($urandom_range(1, 15));
            data_in = $urandom;
            predict(has, id, word);
            step();
            chain = 0;
            while (has) begin
                chain++;
                ra = ($urandom_range(0, 2) == 0 || chain >= 4) ? 4'b0000
                                                                : 4'($urandom_range(1, 15));
                do_frame(id, word, 2, ra, 1, 0, -1, has, id, word);
            end
            check_idle("rand_end");
        end

        // Reset mid-frame after four data beats, then fresh arbitration from pointer 0.
        req = 4'b0010;
        data_in = 32'h0000_5A00;
        predict(has, id, word);
        step();
        do_frame(id, word, 0, '0, 0, 0, 4, has, id, word);
        rst_n = 1'b0;
        #1;
        check_idle("rst_async");
        step();
        check_idle("rst_held");
        req = 4'b0101;
        data_in = 32'h00C3_003C;
        rst_n = 1'b1;
        ptr_m = 0;
        predict(has, id, word);
        step();
        do_frame(id, word, 0, 4'b0100, 0, 0, -1, has, id, word);
        chk("rst_chain", has, 1);
        do_frame(id, word, 0, '0, 0, 0, -1, has, id, word);
        check_idle("rst_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
